dm: RTL and testbench
=====================

DM -- requirements
Module: dm

Interface
REQ-001 SHALL: clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous and active-low, one clock domain; asserting it clears all state.
REQ-003 SHALL: dmi_start  input  1  request level from the DTM, already 2-FF synchronized to clk.
REQ-004 SHALL: dmi_op  input  2  operation: 0 = nop, 1 = read, 2 = write, 3 = reserved (treated as nop).
REQ-005 SHALL: dmi_address  input  7  register address, bits [40:34].
REQ-006 SHALL: dmi_data_o  input  32  write data, bits [33:2].
REQ-007 SHALL: dmi_finish  output  1  completion level back to the DTM.
REQ-008 SHALL: dmi_data_i  output  32  read data, bits [33:2].
REQ-009 SHALL: halted, running  input  1 each  hart status.
REQ-010 SHALL: haltreq, resumereq, resethaltreq  output  1 each  hart control levels.
REQ-011 SHALL: ndmreset  output  1  non-debug-module reset request, active-high.

Function
REQ-012 SHALL: DMI uses a 4-phase handshake, with states IDLE -> ACK -> IDLE:
- In IDLE, the cycle after dmi_start is sampled high: capture op/address/data, execute the access, set dmi_finish=1 with response data, enter ACK.
- In ACK, hold dmi_finish and dmi_data_i stable until dmi_start is sampled low.
- Then clear dmi_finish the next cycle and return to IDLE.
REQ-013 SHALL: Each access executes exactly once per dmi_start high phase; start staying high in ACK causes no repeat.
REQ-014 SHALL: dmcontrol at 0x10:
- bit31 haltreq; bit30 resumereq (write-only, reads 0).
- bit3 setresethaltreq and bit2 clrresethaltreq (write-1 strobes, read 0).
- bit1 ndmreset; bit0 dmactive.
- All other bits read 0.
REQ-015 SHALL: Write to dmcontrol:
- haltreq, ndmreset and dmactive are loaded from the data.
- Output haltreq equals the stored haltreq bit from the cycle after the write.
- dmactive is stored and read back only; it does not gate any control.
REQ-016 SHALL: Write with resumereq=1 and haltreq=0:
- set resumereq output and clear resumeack.
- resumereq stays high until running is sampled 1, then clears the next cycle and sets resumeack.
REQ-017 SHALL: resumereq=1 together with haltreq=1 in the same write ignores the resume.
REQ-018 SHALL: resethaltreq is set by setresethaltreq=1 and cleared by clrresethaltreq=1; if both are 1, clear wins.
REQ-019 SHALL: ndmreset output equals the stored ndmreset bit (registered).
REQ-020 SHALL: dmstatus at 0x11 is read-only:
- bit17/16 all/anyresumeack = resumeack.
- bit11/10 all/anyrunning = running.
- bit9/8 all/anyhalted = halted.
- bit7 authenticated = 1; bits[3:0] version = 2.
- All other bits 0.
REQ-021 SHALL: hartinfo at 0x12 reads 0x00000000.
REQ-022 SHALL: Unmapped addresses read 0x00000000; writes to them and to read-only registers are ignored.
REQ-023 SHALL: dmi_data_i response per op:
- read: register value sampled in the execute cycle.
- write and nop: 0x00000000.
REQ-024 SHALL: A status-input change during the ACK state does not alter the held dmi_data_i.

Reset
REQ-025 SHALL: While rst_n=0, all outputs and internal registers are 0 and the FSM is IDLE; this includes haltreq, resumereq, resethaltreq, ndmreset, dmi_finish, dmi_data_i, dmactive and resumeack.
REQ-026 SHALL: Reset asserted mid-handshake aborts the access with no register update. After release, a still-high dmi_start is treated as a new request.
REQ-027 SHALL: No constraint is placed on ndmreset feeding back into rst_n externally; the resulting self-clear pulse is acceptable.

Verification
REQ-028 SHALL: Halt request:
- stimulus: start=1, op=2, addr=0x10, data=0x80000000.
- response: dmi_finish=1 one cycle later, dmi_data_i=0, haltreq=1, ndmreset=0.
- then: start=0 -> dmi_finish=0 next cycle.
REQ-029 SHALL: Status read:
- stimulus: halted=1, running=0, read 0x11.
- response: dmi_data_i=0x00000382.
REQ-030 SHALL: Resume:
- stimulus: write 0x10 data=0x40000000 while halted.
- response: resumereq=1, haltreq=0.
- then: running=1 -> resumereq=0 next cycle; read 0x11 gives bits 17,16,11,10 set (0x00030C82).
REQ-031 SHALL: Reset-halt request:
- stimulus: write 0x10 data=0x00000008 -> resethaltreq=1.
- then: data=0x0000000C -> resethaltreq=0.
REQ-032 SHALL: ndmreset and read-back:
- stimulus: write 0x10 data=0x00000003 -> ndmreset=1; read 0x10 returns 0x00000003.
- stimulus: read 0x7F -> 0x00000000.
REQ-033 SHALL: Held request:
- stimulus: dmi_start held high for 10 cycles on a write.
- response: exactly one register update; dmi_finish stays 1 until start falls.

Source files
------------

// File: rtl/dm.sv
// -----------------------------------------------------------------------------
// dm -- minimal RISC-V style debug module behind a 4-phase DMI handshake.
//
// Purpose:
//   Accepts one DMI access per dmi_start high phase (IDLE -> ACK -> IDLE),
//   executes it exactly once, and returns dmi_finish plus read data. It
//   implements dmcontrol (0x10), dmstatus (0x11) and hartinfo (0x12), and
//   drives the hart control levels.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   dmi_start    in   1  request level (already synchronized to clk)
//   dmi_op       in   2  0 nop, 1 read, 2 write, 3 reserved (nop)
//   dmi_address  in   7  register address
//   dmi_data_o   in  32  write data from the DTM
//   dmi_finish   out  1  completion level to the DTM
//   dmi_data_i   out 32  response data to the DTM
//   halted       in   1  hart is halted
//   running      in   1  hart is running
//   haltreq      out  1  halt request level
//   resumereq    out  1  resume request level
//   resethaltreq out  1  halt-on-reset request level
//   ndmreset     out  1  non-debug-module reset request (active-high)
// -----------------------------------------------------------------------------
module dm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmi_start,
  input  logic [1:0]  dmi_op,
  input  logic [6:0]  dmi_address,
  input  logic [31:0] dmi_data_o,
  output logic        dmi_finish,
  output logic [31:0] dmi_data_i,
  input  logic        halted,
  input  logic        running,
  output logic        haltreq,
  output logic        resumereq,
  output logic        resethaltreq,
  output logic        ndmreset
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  localparam logic [6:0] ADDR_DMCONTROL = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS  = 7'h11;
  localparam logic [6:0] ADDR_HARTINFO  = 7'h12;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_exec;
  logic        w_finish_nxt;
  logic        w_is_read;
  logic        w_wr_dmc;
  logic        w_resume_go;
  logic [31:0] w_dmcontrol;
  logic [31:0] w_dmstatus;
  logic [31:0] w_rd_data;
  logic [31:0] w_resp_data;

  logic        r_finish;
  logic [31:0] r_data_i;
  logic        r_haltreq;
  logic        r_resumereq;
  logic        r_resethaltreq;
  logic        r_ndmreset;
  logic        r_dmactive;
  logic        r_resumeack;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; the access executes only on the IDLE->ACK transition so a
  // start level held high through ACK never repeats it.
  always_comb begin
    w_state_nxt  = r_state;
    w_exec       = 1'b0;
    w_finish_nxt = r_finish;
    case (r_state)
      ST_IDLE: begin
        if (dmi_start) begin
          w_exec       = 1'b1;
          w_finish_nxt = 1'b1;
          w_state_nxt  = ST_ACK;
        end else begin
          w_finish_nxt = 1'b0;
        end
      end
      ST_ACK: begin
        if (!dmi_start) begin
          w_finish_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_finish_nxt = 1'b1;
        end
      end
      default: begin
        w_finish_nxt = 1'b0;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  // Register images and access decode
  always_comb begin
    w_dmcontrol = {r_haltreq, 1'b0, 28'h0000000, r_ndmreset, r_dmactive};
    w_dmstatus  = {14'h0000, r_resumeack, r_resumeack, 4'h0, running, running,
                   halted, halted, 1'b1, 3'b000, 4'd2};
    w_is_read   = w_exec && (dmi_op == 2'd1);
    w_wr_dmc    = w_exec && (dmi_op == 2'd2) && (dmi_address == ADDR_DMCONTROL);
    // A resume together with a halt request in one write is ignored.
    w_resume_go = w_wr_dmc && dmi_data_o[30] && !dmi_data_o[31];
    case (dmi_address)
      ADDR_DMCONTROL: w_rd_data = w_dmcontrol;
      ADDR_DMSTATUS:  w_rd_data = w_dmstatus;
      ADDR_HARTINFO:  w_rd_data = 32'h00000000;
      default:        w_rd_data = 32'h00000000;
    endcase
    if (w_is_read) begin
      w_resp_data = w_rd_data;
    end else begin
      w_resp_data = 32'h00000000;
    end
  end

  // Handshake outputs; response data is captured once and held through ACK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_finish <= 1'b0;
      r_data_i <= 32'h00000000;
    end else begin
      r_finish <= w_finish_nxt;
      if (w_exec) begin
        r_data_i <= w_resp_data;
      end
    end
  end

  // dmcontrol state and the resume handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_haltreq      <= 1'b0;
      r_resumereq    <= 1'b0;
      r_resethaltreq <= 1'b0;
      r_ndmreset     <= 1'b0;
      r_dmactive     <= 1'b0;
      r_resumeack    <= 1'b0;
    end else begin
      if (w_wr_dmc) begin
        r_haltreq  <= dmi_data_o[31];
        r_ndmreset <= dmi_data_o[1];
        r_dmactive <= dmi_data_o[0];
        // Clear strobe wins over set strobe.
        if (dmi_data_o[2]) begin
          r_resethaltreq <= 1'b0;
        end else if (dmi_data_o[3]) begin
          r_resethaltreq <= 1'b1;
        end
      end
      if (w_resume_go) begin
        r_resumereq <= 1'b1;
        r_resumeack <= 1'b0;
      end else if (r_resumereq && running) begin
        r_resumereq <= 1'b0;
        r_resumeack <= 1'b1;
      end
    end
  end

  assign dmi_finish   = r_finish;
  assign dmi_data_i   = r_data_i;
  assign haltreq      = r_haltreq;
  assign resumereq    = r_resumereq;
  assign resethaltreq = r_resethaltreq;
  assign ndmreset     = r_ndmreset;

endmodule

// File: tb/tb_dm.sv
// -----------------------------------------------------------------------------
// tb_dm -- self-checking bench for dm: table of DMI accesses with expected
// responses and control levels, plus hand sequences for reset, resume
// completion, a held request, status change during ACK and reset mid-access.
// -----------------------------------------------------------------------------
module tb_dm;

  logic        clk;
  logic        rst_n;
  logic        dmi_start;
  logic [1:0]  dmi_op;
  logic [6:0]  dmi_address;
  logic [31:0] dmi_data_o;
  logic        dmi_finish;
  logic [31:0] dmi_data_i;
  logic        halted;
  logic        running;
  logic        haltreq;
  logic        resumereq;
  logic        resethaltreq;
  logic        ndmreset;

  int checks = 0;
  int errors = 0;

  dm u_dm (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmi_start    (dmi_start),
    .dmi_op       (dmi_op),
    .dmi_address  (dmi_address),
    .dmi_data_o   (dmi_data_o),
    .dmi_finish   (dmi_finish),
    .dmi_data_i   (dmi_data_i),
    .halted       (halted),
    .running      (running),
    .haltreq      (haltreq),
    .resumereq    (resumereq),
    .resethaltreq (resethaltreq),
    .ndmreset     (ndmreset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    logic        hlt;
    logic        run;
    logic [31:0] exp_rdata;
    logic        exp_haltreq;
    logic        exp_resumereq;
    logic        exp_rsthalt;
    logic        exp_ndmreset;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One full handshake; finish must rise exactly one cycle after start.
  task automatic apply(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    halted      = v.hlt;
    running     = v.run;
    dmi_op      = v.op;
    dmi_address = v.addr;
    dmi_data_o  = v.data;
    dmi_start   = 1'b1;
    @(negedge clk);
    chk({tag, ".finish"},    {31'd0, dmi_finish},   32'd1);
    chk({tag, ".rdata"},     dmi_data_i,            v.exp_rdata);
    chk({tag, ".haltreq"},   {31'd0, haltreq},      {31'd0, v.exp_haltreq});
    chk({tag, ".resumereq"}, {31'd0, resumereq},    {31'd0, v.exp_resumereq});
    chk({tag, ".rsthalt"},   {31'd0, resethaltreq}, {31'd0, v.exp_rsthalt});
    chk({tag, ".ndmreset"},  {31'd0, ndmreset},     {31'd0, v.exp_ndmreset});
    dmi_start = 1'b0;
    @(negedge clk);
    chk({tag, ".finish_clr"}, {31'd0, dmi_finish}, 32'd0);
  endtask

  initial begin
    //             op     addr   data          hlt   run   rdata         hr    rr    rh    nd
    vecs[0]  = '{2'd1, 7'h11, 32'h00000000, 1'b0, 1'b0, 32'h00000082, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'd2, 7'h10, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'd1, 7'h11, 32'h00000000, 1'b1, 1'b0, 32'h00000382, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'd1, 7'h10, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'd2, 7'h10, 32'h40000000, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{2'd1, 7'h11, 32'h00000000, 1'b0, 1'b1, 32'h00030C82, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'd2, 7'h10, 32'h00000008, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{2'd2, 7'h10, 32'h0000000C, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'd2, 7'h10, 32'h00000003, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{2'd1, 7'h10, 32'h00000000, 1'b0, 1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{2'd1, 7'h7F, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{2'd1, 7'h12, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{2'd2, 7'h11, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{2'd1, 7'h11, 32'h00000000, 1'b0, 1'b1, 32'h00030C82, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{2'd2, 7'h10, 32'hC0000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{2'd1, 7'h10, 32'h00000000, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{2'd3, 7'h10, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{2'd1, 7'h10, 32'h00000000, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{2'd0, 7'h10, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n       = 1'b0;
    dmi_start   = 1'b0;
    dmi_op      = 2'd0;
    dmi_address = 7'h00;
    dmi_data_o  = 32'h00000000;
    halted      = 1'b0;
    running     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.finish",    {31'd0, dmi_finish},   32'd0);
    chk("rst.rdata",     dmi_data_i,            32'd0);
    chk("rst.outs",      {28'd0, haltreq, resumereq, resethaltreq, ndmreset}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) apply(i, vecs[i]);

    // Resume completes one cycle after running is seen
    @(negedge clk);
    halted  = 1'b0;
    running = 1'b1;
    chk("resume.pending", {31'd0, resumereq}, 32'd1);
    @(negedge clk);
    chk("resume.cleared", {31'd0, resumereq}, 32'd0);

    for (int i = 5; i < 19; i++) apply(i, vecs[i]);

    // Held request: resume write held 10 cycles must execute only once
    @(negedge clk);
    halted      = 1'b1;
    running     = 1'b0;
    dmi_op      = 2'd2;
    dmi_address = 7'h10;
    dmi_data_o  = 32'h40000000;
    dmi_start   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("held.finish%0d", i), {31'd0, dmi_finish}, 32'd1);
      if (i == 2) begin
        halted  = 1'b0;
        running = 1'b1;
      end
    end
    chk("held.resumereq", {31'd0, resumereq}, 32'd0);
    chk("held.haltreq",   {31'd0, haltreq},   32'd0);
    dmi_start = 1'b0;
    @(negedge clk);
    chk("held.finish_clr", {31'd0, dmi_finish}, 32'd0);

    // Status change during ACK must not alter held read data
    @(negedge clk);
    halted      = 1'b1;
    running     = 1'b0;
    dmi_op      = 2'd1;
    dmi_address = 7'h11;
    dmi_start   = 1'b1;
    @(negedge clk);
    chk("ackhold.rdata0", dmi_data_i, 32'h00030382);
    halted  = 1'b0;
    running = 1'b1;
    repeat (2) @(negedge clk);
    chk("ackhold.rdata1", dmi_data_i, 32'h00030382);
    chk("ackhold.finish", {31'd0, dmi_finish}, 32'd1);
    dmi_start = 1'b0;
    @(negedge clk);
    chk("ackhold.finish_clr", {31'd0, dmi_finish}, 32'd0);

    // Reset during a request, start still high afterwards -> new request
    @(negedge clk);
    dmi_op      = 2'd2;
    dmi_address = 7'h10;
    dmi_data_o  = 32'h00000002;
    dmi_start   = 1'b1;
    rst_n       = 1'b0;
    @(negedge clk);
    chk("rstmid.finish", {31'd0, dmi_finish}, 32'd0);
    chk("rstmid.ndm",    {31'd0, ndmreset},   32'd0);
    chk("rstmid.hr",     {31'd0, haltreq},    32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid.finish2", {31'd0, dmi_finish}, 32'd1);
    chk("rstmid.ndm2",    {31'd0, ndmreset},   32'd1);
    dmi_start = 1'b0;
    @(negedge clk);
    chk("rstmid.finish_clr", {31'd0, dmi_finish}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
